seq_div16: RTL
==============

Name: seq_div16

Overview:
Iterative signed two's-complement divider. It is the inverse-direction companion to the team's 16-bit ripple adder with overflow flag: it divides by repeated restoring subtraction, producing one quotient bit per clock. It sits beside the adder in the lab ALU datapath. It is driven by a Start/Busy/Done handshake and reports divide-by-zero and overflow the same way the adder reports overflow.

Parameters:
WIDTH, 16, operand/result width in bits; iteration count equals WIDTH.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
Start  input  1  request; sampled only when Busy=0
A  input  WIDTH  dividend, two's complement, captured on the accepted Start edge
B  input  WIDTH  divisor, two's complement, captured on the accepted Start edge
Busy  output  1  high while an operation is in progress
Done  output  1  one-cycle pulse: Q, R, DivZero and Ovf valid
Q  output  WIDTH  quotient, truncated toward zero
R  output  WIDTH  remainder; sign follows the dividend
DivZero  output  1  B was 0 for the completed operation
Ovf  output  1  A = most-negative value and B = -1

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n). While rst_n=0 and on release:
  - state=IDLE;
  - Busy=0, Done=0;
  - Q=0, R=0, DivZero=0, Ovf=0;
  - all internal registers cleared.
- States: IDLE, DIV, FIX, DONE.
- IDLE or DONE with Start=1 (the accepting edge):
  - capture A and B;
  - record sign_q = A[msb]^B[msb] and sign_r = A[msb];
  - load |A| into the working dividend and |B| into the working divisor, both as unsigned WIDTH-bit values;
  - clear partial remainder P (WIDTH+1 bits) and iteration counter;
  - next state DIV, except for the special cases below.
- Special cases, decided on the accepting edge:
  - B=0: next state DONE with Q=all ones, R=A, DivZero=1, Ovf=0.
  - A=100..0 and B=all ones: next state DONE with Q=100..0, R=0, Ovf=1, DivZero=0.
- DIV, one iteration per edge, WIDTH edges total:
  - shift {P, dividend} left by 1;
  - trial difference T = P - divisor, computed WIDTH+1 bits wide;
  - if T is non-negative, P=T and the new quotient LSB is 1; otherwise P is unchanged and the LSB is 0;
  - after the WIDTH-th iteration, next state FIX.
- FIX (1 edge):
  - Q = sign_q ? -quotient : quotient;
  - R = sign_r ? -P[WIDTH-1:0] : P[WIDTH-1:0];
  - DivZero=0, Ovf=0;
  - next state DONE.
- DONE: Done=1 for exactly this cycle, then the block returns to IDLE unless Start=1, which is accepted as in IDLE. Done is never high for two consecutive cycles unless back-to-back special-case operations are issued.
- Busy=1 in DIV and FIX only. Start while Busy=1 is ignored, with no effect on any state.
- Latency, normal operation: Done is high in the cycle following the (WIDTH+2)-th rising edge counted from the accepting edge (that edge is edge 1). That is 18 edges for WIDTH=16.
- Latency, special cases: Done is high in the cycle following the accepting edge.
- Output holding:
  - Q, R, DivZero and Ovf change only on the FIX edge or on a special-case accepting edge.
  - Otherwise they hold their values indefinitely, including during a following operation until that operation's result is written.
- Arithmetic:
  - |most-negative| is representable as unsigned WIDTH bits, so it needs no special path except the Ovf case.
  - The remainder always satisfies |R| < |B| and A = Q*B + R (mod 2^WIDTH) for all non-special inputs.
- Reset mid-operation: immediate abort to the reset values; the operation is not resumed. A Start on the first edge after release is accepted normally.

Test Plan:
- Reset, then A=100, B=7, Start pulsed 1 cycle -> Busy=1 for 17 cycles; Done high exactly once, 18 edges after the accepting edge; Q=14, R=2, flags 0.
- A=-100, B=7 -> Q=0xFFF2 (-14), R=0xFFFE (-2). A=100, B=-7 -> Q=0xFFF2, R=0x0002. A=-100, B=-7 -> Q=0x000E, R=0xFFFE.
- A=5, B=0 -> Done on the next cycle, DivZero=1, Q=0xFFFF, R=0x0005, Busy never high. A=0x8000, B=0xFFFF -> Ovf=1, Q=0x8000, R=0.
- Boundaries:
  - A=0x7FFF, B=1 -> Q=0x7FFF, R=0;
  - A=3, B=5 -> Q=0, R=3;
  - A=0x8000, B=1 -> Q=0x8000, R=0, Ovf=0;
  - A=0, B=-3 -> Q=0, R=0.
- Robustness:
  - Start A=1000, B=10, then pulse Start with A=1, B=1 on cycle 5 -> the second Start is ignored; result Q=100, R=0.
  - Start held high continuously -> back-to-back operations with a Done pulse every 18 cycles.
- Start A=1000, B=10, drop rst_n on cycle 8 -> Busy, Done, Q, R and flags go to 0 asynchronously. After release, A=-7, B=2 completes with Q=0xFFFD, R=0xFFFF.

Source files
------------

// File: rtl/seq_div16.sv
// seq_div16: iterative signed restoring divider, one quotient bit per clock, Start/Busy/Done handshake
module seq_div16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             DivZero,
  output logic             Ovf
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [1:0] S_IDLE = 2'd0, S_DIV = 2'd1, S_FIX = 2'd2, S_DONE = 2'd3;
  logic [1:0] state;
  logic [WIDTH-1:0] p, dvd, dvs, a_abs, b_abs;
  logic [WIDTH:0] p_sh, t;
  logic [CW-1:0] cnt;
  logic sign_q, sign_r, accept, b_zero, ovf_case;
  always_comb begin
    p_sh = {p, dvd[WIDTH-1]};
    t = p_sh - {1'b0, dvs};
    a_abs = A[WIDTH-1] ? -A : A;
    b_abs = B[WIDTH-1] ? -B : B;
    accept = Start && (state == S_IDLE || state == S_DONE);
    b_zero = B == '0;
    ovf_case = A == {1'b1, {(WIDTH-1){1'b0}}} && &B;
    Busy = state == S_DIV || state == S_FIX;
    Done = state == S_DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      p <= '0;
      dvd <= '0;
      dvs <= '0;
      cnt <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      Q <= '0;
      R <= '0;
      DivZero <= 1'b0;
      Ovf <= 1'b0;
    end else if (accept) begin
      sign_q <= A[WIDTH-1] ^ B[WIDTH-1];
      sign_r <= A[WIDTH-1];
      dvd <= a_abs;
      dvs <= b_abs;
      p <= '0;
      cnt <= '0;
      state <= (b_zero || ovf_case) ? S_DONE : S_DIV;
      if (b_zero) begin
        Q <= '1;
        R <= A;
        DivZero <= 1'b1;
        Ovf <= 1'b0;
      end else if (ovf_case) begin
        Q <= A;
        R <= '0;
        DivZero <= 1'b0;
        Ovf <= 1'b1;
      end
    end else begin
      case (state)
        S_DIV: begin
          // a non-negative trial difference means the divisor fits: keep it and set the quotient bit
          p <= t[WIDTH] ? p_sh[WIDTH-1:0] : t[WIDTH-1:0];
          dvd <= {dvd[WIDTH-2:0], ~t[WIDTH]};
          cnt <= cnt + 1'b1;
          state <= (cnt == LAST) ? S_FIX : S_DIV;
        end
        S_FIX: begin
          Q <= sign_q ? -dvd : dvd;
          R <= sign_r ? -p : p;
          DivZero <= 1'b0;
          Ovf <= 1'b0;
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
